// File: rtl/spi_master16_if.sv
// Word handshake and SPI pin bundle for spi_master16.
// The master modport is the initiator's view; the slave modport is the
// view of whatever feeds words in and sits on the far end of the wires.
interface spi_master16_if;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        busy;
   logic        spi_cs_n;
   logic        spi_sck;
   logic        spi_mosi;
   logic        spi_miso;

   modport master (
      input  tx_data, tx_valid, spi_miso,
      output tx_ready, rx_data, rx_valid, busy, spi_cs_n, spi_sck, spi_mosi
   );

   modport slave (
      output tx_data, tx_valid, spi_miso,
      input  tx_ready, rx_data, rx_valid, busy, spi_cs_n, spi_sck, spi_mosi
   );
endinterface

// File: rtl/spi_master16.sv
// spi_master16: 16-bit SPI initiator, mode 0, MSB first.
// A word accepted on the valid/ready handshake is clocked out on MOSI while
// the word arriving on MISO is collected and presented with a one-cycle
// rx_valid pulse. Every output comes straight from a register.
module spi_master16 #(
   parameter int CLKSPEED = 48_000_000,
   parameter int SCK_FREQ = 1_000_000
) (
   input  logic           clk,
   input  logic           rst,
   spi_master16_if.master bus
);
   // Half-period of SCK in clk cycles.
   localparam int H  = CLKSPEED / (2 * SCK_FREQ);
   localparam int CW = (H > 1) ? $clog2(H) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(H - 1);

   generate
      if (H < 1) begin : g_bad_h
         $fatal(1, "spi_master16: CLKSPEED/(2*SCK_FREQ) must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   state_t        r_state, w_state_next;
   logic [CW-1:0] r_cnt, w_cnt_next;
   logic [3:0]    r_bit, w_bit_next;
   logic [15:0]   r_tx_sh, w_tx_sh_next;
   logic [15:0]   r_rx_sh, w_rx_sh_next;
   logic [15:0]   r_rx_data, w_rx_data_next;
   logic          r_rx_valid, w_rx_valid_next;
   logic          r_tx_ready, w_tx_ready_next;
   logic          r_busy, w_busy_next;
   logic          r_cs_n, w_cs_n_next;
   logic          r_sck, w_sck_next;

   logic          w_last;
   logic [CW-1:0] w_cnt_adv;

   // The counter wraps at H-1, which is exactly when a state or SCK phase
   // changes, so wrapping doubles as "cleared on each state change".
   assign w_last    = (r_cnt == CNT_LAST);
   assign w_cnt_adv = w_last ? '0 : r_cnt + 1'b1;

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_bit_next      = r_bit;
      w_tx_sh_next    = r_tx_sh;
      w_rx_sh_next    = r_rx_sh;
      w_rx_data_next  = r_rx_data;
      w_rx_valid_next = 1'b0;
      w_cs_n_next     = r_cs_n;
      w_sck_next      = r_sck;

      unique case (r_state)
         IDLE: begin
            w_cnt_next = '0;
            if (bus.tx_valid) begin
               // MOSI is the top bit of the tx shifter, so bit15 appears
               // together with the falling chip select.
               w_state_next = SETUP;
               w_tx_sh_next = bus.tx_data;
               w_rx_sh_next = '0;
               w_bit_next   = '0;
               w_cs_n_next  = 1'b0;
               w_sck_next   = 1'b0;
            end
         end
         SETUP: begin
            w_cnt_next = w_cnt_adv;
            if (w_last) begin
               // First rising edge: MISO is captured on the same clk edge.
               w_state_next = SHIFT;
               w_sck_next   = 1'b1;
               w_rx_sh_next = {r_rx_sh[14:0], bus.spi_miso};
            end
         end
         SHIFT: begin
            w_cnt_next = w_cnt_adv;
            if (w_last) begin
               if (r_sck) begin
                  w_sck_next = 1'b0;
                  if (r_bit == 4'd15) begin
                     // Last falling edge: leave bit0 on MOSI through HOLD.
                     w_state_next = HOLD;
                  end else begin
                     w_bit_next   = r_bit + 4'd1;
                     w_tx_sh_next = {r_tx_sh[14:0], 1'b0};
                  end
               end else begin
                  w_sck_next   = 1'b1;
                  w_rx_sh_next = {r_rx_sh[14:0], bus.spi_miso};
               end
            end
         end
         HOLD: begin
            w_cnt_next = w_cnt_adv;
            if (w_last) begin
               w_state_next    = GAP;
               w_cs_n_next     = 1'b1;
               w_tx_sh_next    = '0;
               w_rx_data_next  = r_rx_sh;
               w_rx_valid_next = 1'b1;
            end
         end
         GAP: begin
            w_cnt_next = w_cnt_adv;
            if (w_last) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
         end
      endcase

      w_tx_ready_next = (w_state_next == IDLE);
      w_busy_next     = (w_state_next != IDLE);
   end

   // State and output registers; reset drops any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_tx_sh    <= '0;
         r_rx_sh    <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_tx_ready <= 1'b1;
         r_busy     <= 1'b0;
         r_cs_n     <= 1'b1;
         r_sck      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_bit      <= w_bit_next;
         r_tx_sh    <= w_tx_sh_next;
         r_rx_sh    <= w_rx_sh_next;
         r_rx_data  <= w_rx_data_next;
         r_rx_valid <= w_rx_valid_next;
         r_tx_ready <= w_tx_ready_next;
         r_busy     <= w_busy_next;
         r_cs_n     <= w_cs_n_next;
         r_sck      <= w_sck_next;
      end
   end

   assign bus.tx_ready = r_tx_ready;
   assign bus.rx_data  = r_rx_data;
   assign bus.rx_valid = r_rx_valid;
   assign bus.busy     = r_busy;
   assign bus.spi_cs_n = r_cs_n;
   assign bus.spi_sck  = r_sck;
   assign bus.spi_mosi = r_tx_sh[15];
endmodule
